// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser
// Parses framed commands arriving as a byte stream from a UART receiver.
// Frame: SYNC_BYTE, CMD, LEN, DATA[0..LEN-1], CSUM where CSUM is the XOR of
// CMD, LEN and every DATA byte. Good frames are published to a read-side
// copy of command, length and payload; aborted frames leave it untouched.
//
// Ports
//   i_Clock        system clock, rising edge
//   i_Reset        asynchronous active-high reset
//   i_RX_DV        one-cycle strobe qualifying i_RX_Byte
//   i_RX_Byte      received byte
//   i_Rd_Addr      payload read index
//   o_Rd_Data      payload byte at i_Rd_Addr (00 when index >= o_Len)
//   o_Cmd          command byte of last good frame
//   o_Len          payload length of last good frame
//   o_Frame_Valid  one-cycle pulse, good frame received
//   o_Err          one-cycle pulse, frame aborted
//   o_Err_Code     cause of last abort: 01 checksum, 10 length, 11 timeout
module uart_cmd_parser #(
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
  parameter int unsigned MAX_LEN      = 8,
  parameter int unsigned TIMEOUT_CLKS = 104160
) (
  input  logic       i_Clock,
  input  logic       i_Reset,
  input  logic       i_RX_DV,
  input  logic [7:0] i_RX_Byte,
  input  logic [3:0] i_Rd_Addr,
  output logic [7:0] o_Rd_Data,
  output logic [7:0] o_Cmd,
  output logic [4:0] o_Len,
  output logic       o_Frame_Valid,
  output logic       o_Err,
  output logic [1:0] o_Err_Code
);

  localparam int unsigned TW        = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [7:0]  MAX_LEN_B = 8'(MAX_LEN);

  typedef enum logic [2:0] {
    IDLE,
    GET_CMD,
    GET_LEN,
    GET_DATA,
    GET_CSUM
  } state_t;

  state_t state, state_nxt;

  logic [TW-1:0] tmo_cnt;
  logic          tmo_hit;

  logic [7:0] work_cmd;
  logic [4:0] work_len;
  logic [7:0] csum;
  logic [3:0] idx;
  // Buffers span the full 4-bit read address range so any i_Rd_Addr
  // indexes a real entry; entries at or above the length are masked.
  logic [7:0] work_buf [16];
  logic [7:0] rd_buf   [16];

  logic       frame_ok;
  logic       abort;
  logic [1:0] abort_code;
  logic       cap_cmd;
  logic       cap_len;
  logic       cap_data;

  // Counter value equals the number of clocks since the last byte strobe
  // while a frame is open; expiry aborts on the following edge.
  assign tmo_hit = (state != IDLE) && (tmo_cnt == TW'(TIMEOUT_CLKS));

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    frame_ok   = 1'b0;
    abort      = 1'b0;
    abort_code = 2'b00;
    cap_cmd    = 1'b0;
    cap_len    = 1'b0;
    cap_data   = 1'b0;
    // Timeout is checked first so a byte landing on the expiry cycle is dropped.
    if (tmo_hit) begin
      abort      = 1'b1;
      abort_code = 2'b11;
      state_nxt  = IDLE;
    end else if (i_RX_DV) begin
      case (state)
        IDLE: begin
          if (i_RX_Byte == SYNC_BYTE) state_nxt = GET_CMD;
        end
        GET_CMD: begin
          cap_cmd   = 1'b1;
          state_nxt = GET_LEN;
        end
        GET_LEN: begin
          if (i_RX_Byte == 8'h00) begin
            cap_len   = 1'b1;
            state_nxt = GET_CSUM;
          end else if (i_RX_Byte > MAX_LEN_B) begin
            abort      = 1'b1;
            abort_code = 2'b10;
            state_nxt  = IDLE;
          end else begin
            cap_len   = 1'b1;
            state_nxt = GET_DATA;
          end
        end
        GET_DATA: begin
          cap_data = 1'b1;
          if ({1'b0, idx} == work_len - 5'd1) state_nxt = GET_CSUM;
        end
        GET_CSUM: begin
          if (i_RX_Byte == csum) begin
            frame_ok = 1'b1;
          end else begin
            abort      = 1'b1;
            abort_code = 2'b01;
          end
          state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      tmo_cnt <= '0;
    end else if (i_RX_DV || tmo_hit || state == IDLE) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + TW'(1);
    end
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      work_cmd      <= '0;
      work_len      <= '0;
      csum          <= '0;
      idx           <= '0;
      work_buf      <= '{default: '0};
      rd_buf        <= '{default: '0};
      o_Cmd         <= '0;
      o_Len         <= '0;
      o_Frame_Valid <= 1'b0;
      o_Err         <= 1'b0;
      o_Err_Code    <= 2'b00;
    end else begin
      o_Frame_Valid <= frame_ok;
      o_Err         <= abort;
      if (abort) o_Err_Code <= abort_code;

      if (cap_cmd) begin
        work_cmd <= i_RX_Byte;
        csum     <= i_RX_Byte;
      end
      if (cap_len) begin
        work_len <= i_RX_Byte[4:0];
        csum     <= csum ^ i_RX_Byte;
        idx      <= '0;
      end
      if (cap_data) begin
        work_buf[idx] <= i_RX_Byte;
        csum          <= csum ^ i_RX_Byte;
        idx           <= idx + 4'd1;
      end

      if (frame_ok) begin
        o_Cmd  <= work_cmd;
        o_Len  <= work_len;
        rd_buf <= work_buf;
      end
    end
  end

  always_comb begin
    o_Rd_Data = '0;
    if ({1'b0, i_Rd_Addr} < o_Len) o_Rd_Data = rd_buf[i_Rd_Addr];
  end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Self-checking bench for uart_cmd_parser: a table of byte frames with
// hand-computed results, then directed timeout and reset sequences.
module tb_uart_cmd_parser;

  localparam int unsigned TMO = 40;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       dv = 1'b0;
  logic [7:0] rxb = 8'h00;
  logic [3:0] rd_addr = 4'h0;
  logic [7:0] o_Rd_Data;
  logic [7:0] o_Cmd;
  logic [4:0] o_Len;
  logic       o_Frame_Valid;
  logic       o_Err;
  logic [1:0] o_Err_Code;

  int checks = 0;
  int errors = 0;
  int n_valid = 0;
  int n_err = 0;

  always #10 clk = ~clk;

  uart_cmd_parser #(
    .SYNC_BYTE   (8'hA5),
    .MAX_LEN     (8),
    .TIMEOUT_CLKS(TMO)
  ) dut (
    .i_Clock      (clk),
    .i_Reset      (rst),
    .i_RX_DV      (dv),
    .i_RX_Byte    (rxb),
    .i_Rd_Addr    (rd_addr),
    .o_Rd_Data    (o_Rd_Data),
    .o_Cmd        (o_Cmd),
    .o_Len        (o_Len),
    .o_Frame_Valid(o_Frame_Valid),
    .o_Err        (o_Err),
    .o_Err_Code   (o_Err_Code)
  );

  always @(negedge clk) begin
    if (o_Frame_Valid === 1'b1) n_valid++;
    if (o_Err === 1'b1) n_err++;
    if (o_Frame_Valid === 1'b1 && o_Err === 1'b1) begin
      checks++;
      errors++;
      $display("FAIL valid_and_err_same_cycle at %0t", $time);
    end
  end

  typedef struct {
    logic [95:0] bytes;   // right-justified, first byte most significant
    int unsigned n;
    logic        v;
    logic        e;
    logic [1:0]  code;
    logic [7:0]  cmd;
    logic [4:0]  len;
    logic [23:0] d;       // expected reads at addr 0,1,2
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic chk_rd(input string name, input logic [3:0] a, input logic [7:0] exp);
    rd_addr = a;
    #1;
    chk(name, {24'h0, o_Rd_Data}, {24'h0, exp});
  endtask

  // Called at a negedge; returns at the next negedge, where any pulse
  // caused by this byte is visible.
  task automatic send_byte(input logic [7:0] b);
    dv  = 1'b1;
    rxb = b;
    @(negedge clk);
    dv  = 1'b0;
  endtask

  task automatic send_frame(input logic [95:0] bytes, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      if (i != 0) @(negedge clk);
      send_byte(bytes[8*(n-1-i) +: 8]);
    end
  endtask

  initial begin
    int nv0;
    int ne0;
    int unsigned lat;

    // checksum of 10 02 33 44 is 65; 67 must fail the checksum
    tbl[0] = '{{8'hA5, 8'h20, 8'h00, 8'h20}, 4, 1'b1, 1'b0, 2'b00, 8'h20, 5'd0, 24'h000000};
    tbl[1] = '{{8'hA5, 8'h10, 8'h02, 8'h33, 8'h44, 8'h65}, 6, 1'b1, 1'b0, 2'b00, 8'h10, 5'd2, 24'h334400};
    tbl[2] = '{{8'hA5, 8'h10, 8'h02, 8'h33, 8'h44, 8'h00}, 6, 1'b0, 1'b1, 2'b01, 8'h10, 5'd2, 24'h334400};
    tbl[3] = '{{8'hA5, 8'h10, 8'h02, 8'h33, 8'h44, 8'h67}, 6, 1'b0, 1'b1, 2'b01, 8'h10, 5'd2, 24'h334400};
    tbl[4] = '{{8'hA5, 8'h10, 8'h09}, 3, 1'b0, 1'b1, 2'b10, 8'h10, 5'd2, 24'h334400};
    tbl[5] = '{{8'hA5, 8'h30, 8'h03, 8'hA5, 8'h01, 8'h02, 8'h95}, 7, 1'b1, 1'b0, 2'b10, 8'h30, 5'd3, 24'hA50102};
    tbl[6] = '{{8'h00, 8'hFF, 8'hA5, 8'h40, 8'h01, 8'h7E, 8'h3F}, 7, 1'b1, 1'b0, 2'b10, 8'h40, 5'd1, 24'h7E0000};
    tbl[7] = '{{8'hA5, 8'h50, 8'h08, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h50},
               12, 1'b1, 1'b0, 2'b10, 8'h50, 5'd8, 24'h010203};

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_cmd", {24'h0, o_Cmd}, 32'h0);
    chk("rst_len", {27'h0, o_Len}, 32'h0);
    chk("rst_valid", {31'h0, o_Frame_Valid}, 32'h0);
    chk("rst_err", {31'h0, o_Err}, 32'h0);
    chk("rst_code", {30'h0, o_Err_Code}, 32'h0);
    chk_rd("rst_rd0", 4'd0, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int unsigned t = 0; t < 8; t++) begin
      nv0 = n_valid;
      ne0 = n_err;
      send_frame(tbl[t].bytes, tbl[t].n);
      chk($sformatf("v%0d_valid_pulse", t), {31'h0, o_Frame_Valid}, {31'h0, tbl[t].v});
      chk($sformatf("v%0d_err_pulse", t), {31'h0, o_Err}, {31'h0, tbl[t].e});
      @(negedge clk);
      #1;
      chk($sformatf("v%0d_valid_one_cycle", t), {31'h0, o_Frame_Valid}, 32'h0);
      chk($sformatf("v%0d_err_one_cycle", t), {31'h0, o_Err}, 32'h0);
      chk($sformatf("v%0d_nvalid", t), n_valid - nv0, tbl[t].v ? 1 : 0);
      chk($sformatf("v%0d_nerr", t), n_err - ne0, tbl[t].e ? 1 : 0);
      chk($sformatf("v%0d_code", t), {30'h0, o_Err_Code}, {30'h0, tbl[t].code});
      chk($sformatf("v%0d_cmd", t), {24'h0, o_Cmd}, {24'h0, tbl[t].cmd});
      chk($sformatf("v%0d_len", t), {27'h0, o_Len}, {27'h0, tbl[t].len});
      chk_rd($sformatf("v%0d_rd0", t), 4'd0, tbl[t].d[23:16]);
      chk_rd($sformatf("v%0d_rd1", t), 4'd1, tbl[t].d[15:8]);
      chk_rd($sformatf("v%0d_rd2", t), 4'd2, tbl[t].d[7:0]);
      chk_rd($sformatf("v%0d_rd_at_len", t), tbl[t].len[3:0], 8'h00);
      @(negedge clk);
    end

    // timeout after A5 10
    send_frame({8'hA5, 8'h10}, 2);
    lat = 0;
    while (o_Err !== 1'b1 && lat < 4 * TMO) begin
      @(negedge clk);
      lat++;
    end
    chk("tmo_err_seen", {31'h0, o_Err}, 32'h1);
    chk("tmo_latency_window", {31'h0, (lat >= TMO - 2 && lat <= TMO + 3)}, 32'h1);
    chk("tmo_code", {30'h0, o_Err_Code}, 32'h3);
    chk("tmo_cmd_kept", {24'h0, o_Cmd}, 32'h50);
    chk("tmo_len_kept", {27'h0, o_Len}, 32'h8);
    repeat (2) @(negedge clk);

    // set code to 10 so a timeout-vs-byte collision is distinguishable
    send_frame({8'hA5, 8'h10, 8'h09}, 3);
    chk("len_err_code", {30'h0, o_Err_Code}, 32'h2);
    repeat (2) @(negedge clk);

    // byte strobe on the exact expiry cycle: timeout wins, byte dropped
    send_frame({8'hA5, 8'h10}, 2);
    repeat (lat - 1) @(negedge clk);
    send_byte(8'hA5);
    chk("tmo_win_err", {31'h0, o_Err}, 32'h1);
    chk("tmo_win_code", {30'h0, o_Err_Code}, 32'h3);
    repeat (2) @(negedge clk);
    nv0 = n_valid;
    ne0 = n_err;
    send_frame({8'h20, 8'h00, 8'h20}, 3);
    repeat (3) @(negedge clk);
    #1;
    chk("tmo_win_idle_no_valid", n_valid - nv0, 0);
    chk("tmo_win_idle_no_err", n_err - ne0, 0);
    send_frame({8'hA5, 8'h60, 8'h01, 8'hFF, 8'h9E}, 5);
    chk("after_tmo_valid", {31'h0, o_Frame_Valid}, 32'h1);
    #1;
    chk("after_tmo_cmd", {24'h0, o_Cmd}, 32'h60);
    chk_rd("after_tmo_rd0", 4'd0, 8'hFF);
    repeat (2) @(negedge clk);

    // reset mid-frame discards partial frame silently
    nv0 = n_valid;
    ne0 = n_err;
    send_frame({8'hA5, 8'h10, 8'h02, 8'h33}, 4);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_cmd", {24'h0, o_Cmd}, 32'h0);
    chk("midrst_len", {27'h0, o_Len}, 32'h0);
    chk("midrst_code", {30'h0, o_Err_Code}, 32'h0);
    chk_rd("midrst_rd0", 4'd0, 8'h00);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send_frame({8'hA5, 8'h10, 8'h02, 8'h33, 8'h44, 8'h65}, 6);
    repeat (3) @(negedge clk);
    #1;
    chk("midrst_one_valid", n_valid - nv0, 1);
    chk("midrst_no_err", n_err - ne0, 0);
    chk("midrst_cmd_after", {24'h0, o_Cmd}, 32'h10);
    chk("midrst_len_after", {27'h0, o_Len}, 32'h2);
    chk_rd("midrst_rd1", 4'd1, 8'h44);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
